// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  // Frame start marker used when no override is given.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Header is SYNC, LEN_LO, LEN_HI.
  localparam int unsigned HDR_LEN = 3;

endpackage

// File: rtl/loader_timeout_cnt.sv
// Inactivity counter: counts enabled cycles since the last clear and
// saturates at LIMIT, where expired_o is raised while still enabled.
module loader_timeout_cnt #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt_q;

  // Count enabled cycles, clear on request, hold once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT_V);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed UART byte stream, assembles
// little-endian 32-bit words, writes them to consecutive RAM words and
// keeps the core in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  loader_state_e         state_q;
  logic                  rx_ready_q;
  logic                  mem_we_q;
  logic [31:0]           mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  cpu_hold_q;
  logic                  load_done_q;
  logic                  load_err_q;
  logic [ADDR_WIDTH:0]   words_written_q;
  logic [15:0]           len_q;
  logic [1:0]            byte_cnt_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [23:0]           word_q;

  logic                  accept;
  logic [15:0]           len_d;
  logic [ADDR_WIDTH:0]   words_written_d;
  logic                  tmo_en;
  logic                  tmo_clr;
  logic                  tmo_expired;

  assign accept          = rx_valid && rx_ready_q;
  assign len_d           = {rx_data, len_q[7:0]};
  assign words_written_d = words_written_q + 1'b1;
  assign tmo_en          = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                           (state_q == ST_DATA);
  assign tmo_clr         = accept || !tmo_en;

  loader_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  // Frame FSM; outputs are registered on the edge that enters the state
  // they belong to, so mem_we/load_done are high exactly while in WRITE/DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rx_ready_q      <= 1'b1;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_hold_q      <= 1'b0;
      load_done_q     <= 1'b0;
      load_err_q      <= 1'b0;
      words_written_q <= '0;
      len_q           <= '0;
      byte_cnt_q      <= '0;
      word_idx_q      <= '0;
      word_q          <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      rx_ready_q  <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            state_q         <= ST_LEN0;
            cpu_hold_q      <= 1'b1;
            load_err_q      <= 1'b0;
            words_written_q <= '0;
          end
        end
        ST_LEN0: begin
          if (accept) begin
            len_q[7:0] <= rx_data;
            state_q    <= ST_LEN1;
          end else if (tmo_expired) begin
            state_q    <= ST_ERROR;
            load_err_q <= 1'b1;
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len_q      <= len_d;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            if (len_d == '0) begin
              state_q     <= ST_DONE;
              load_done_q <= 1'b1;
            end else if ({1'b0, len_d} > MAX_WORDS) begin
              state_q    <= ST_ERROR;
              load_err_q <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end else if (tmo_expired) begin
            state_q    <= ST_ERROR;
            load_err_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            unique case (byte_cnt_q)
              2'd0: word_q[7:0]   <= rx_data;
              2'd1: word_q[15:8]  <= rx_data;
              2'd2: word_q[23:16] <= rx_data;
              default: begin
                // The 4th byte goes straight into the write data so the
                // strobe can fire on the very next cycle.
                mem_we_q    <= 1'b1;
                mem_addr_q  <= 32'({word_idx_q, 2'b00});
                mem_wdata_q <= {rx_data, word_q};
                rx_ready_q  <= 1'b0;
                state_q     <= ST_WRITE;
              end
            endcase
          end else if (tmo_expired) begin
            state_q    <= ST_ERROR;
            load_err_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          words_written_q <= words_written_d;
          word_idx_q      <= word_idx_q + 1'b1;
          if (17'(words_written_d) == {1'b0, len_q}) begin
            state_q     <= ST_DONE;
            load_done_q <= 1'b1;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_DONE: begin
          cpu_hold_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_ready      = rx_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, header boundaries, timeout, reset.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_written;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          done_cnt = 0;
  logic [7:0]  seq[$];

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Record every write strobe and done pulse seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL send_byte: rx_ready=%b never 1 for byte %h", rx_ready, b);
    end
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", rx_ready); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_we: got %b want 0", mem_we); end
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL rst_hold: got %b want 0", cpu_hold); end
    compared++; if (load_done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", load_done); end
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", load_err); end
    compared++; if (words_written !== 9'd0) begin mismatched++; $display("FAIL rst_ww: got %0d want 0", words_written); end
    compared++; if (mem_wdata !== 32'h0) begin mismatched++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_two_words();
    int base, d0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h02, 8'h10};
    send_seq();
    compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("FAIL tw_hold_loading: got %b want 1", cpu_hold); end
    send_byte(8'h00);
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL tw_we0_latency: got %b want 1", mem_we); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL tw_addr0: got %h want 00000000", mem_addr); end
    compared++; if (mem_wdata !== 32'h00100213) begin mismatched++; $display("FAIL tw_data0: got %h want 00100213", mem_wdata); end
    compared++; if (rx_ready !== 1'b0) begin mismatched++; $display("FAIL tw_ready_write: got %b want 0", rx_ready); end
    seq = '{8'h93, 8'h02, 8'h20, 8'h00};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL tw_we1: got %b want 1", mem_we); end
    compared++; if (mem_addr !== 32'h4) begin mismatched++; $display("FAIL tw_addr1: got %h want 00000004", mem_addr); end
    compared++; if (mem_wdata !== 32'h00200293) begin mismatched++; $display("FAIL tw_data1: got %h want 00200293", mem_wdata); end
    @(negedge clk);
    compared++; if (load_done !== 1'b1) begin mismatched++; $display("FAIL tw_done: got %b want 1", load_done); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL tw_we_off: got %b want 0", mem_we); end
    compared++; if (mem_wdata !== 32'h00200293) begin mismatched++; $display("FAIL tw_data_hold: got %h want 00200293", mem_wdata); end
    compared++; if (words_written !== 9'd2) begin mismatched++; $display("FAIL tw_ww: got %0d want 2", words_written); end
    @(negedge clk);
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL tw_release: got %b want 0", cpu_hold); end
    compared++; if (load_done !== 1'b0) begin mismatched++; $display("FAIL tw_done_pulse: got %b want 0", load_done); end
    compared++; if (wa_log.size() - base !== 2) begin mismatched++; $display("FAIL tw_nwrites: got %0d want 2", wa_log.size() - base); end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL tw_ndone: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_leading_garbage();
    int base, d0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (wa_log.size() - base !== 1) begin mismatched++; $display("FAIL lg_nwrites: got %0d want 1", wa_log.size() - base); end
    if (wa_log.size() > base) begin
      compared++; if (wa_log[base] !== 32'h0) begin mismatched++; $display("FAIL lg_addr: got %h want 00000000", wa_log[base]); end
      compared++; if (wd_log[base] !== 32'hEFBEADDE) begin mismatched++; $display("FAIL lg_data: got %h want efbeadde", wd_log[base]); end
    end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL lg_ndone: got %0d want 1", done_cnt - d0); end
    compared++; if (words_written !== 9'd1) begin mismatched++; $display("FAIL lg_ww: got %0d want 1", words_written); end
  endtask

  task automatic test_len_zero();
    int base, d0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'hA5, 8'h00, 8'h00};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (load_done !== 1'b1) begin mismatched++; $display("FAIL lz_done: got %b want 1", load_done); end
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL lz_err: got %b want 0", load_err); end
    repeat (3) @(negedge clk);
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL lz_release: got %b want 0", cpu_hold); end
    compared++; if (wa_log.size() - base !== 0) begin mismatched++; $display("FAIL lz_nwrites: got %0d want 0", wa_log.size() - base); end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL lz_ndone: got %0d want 1", done_cnt - d0); end
    compared++; if (words_written !== 9'd0) begin mismatched++; $display("FAIL lz_ww: got %0d want 0", words_written); end
  endtask

  task automatic test_too_long();
    int base, d0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'hA5, 8'h01, 8'h01};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (load_err !== 1'b1) begin mismatched++; $display("FAIL tl_err: got %b want 1", load_err); end
    compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("FAIL tl_hold: got %b want 1", cpu_hold); end
    send_byte(8'h00);
    @(negedge clk); rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    compared++; if (load_err !== 1'b1) begin mismatched++; $display("FAIL tl_err_sticky: got %b want 1", load_err); end
    compared++; if (wa_log.size() - base !== 0) begin mismatched++; $display("FAIL tl_nwrites: got %0d want 0", wa_log.size() - base); end
    send_byte(8'hA5);
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL tl_err_clear: got %b want 0", load_err); end
    seq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (wa_log.size() - base !== 1) begin mismatched++; $display("FAIL tl_recover_nwrites: got %0d want 1", wa_log.size() - base); end
    if (wa_log.size() > base) begin
      compared++; if (wd_log[base] !== 32'h44332211) begin mismatched++; $display("FAIL tl_recover_data: got %h want 44332211", wd_log[base]); end
      compared++; if (wa_log[base] !== 32'h0) begin mismatched++; $display("FAIL tl_recover_addr: got %h want 00000000", wa_log[base]); end
    end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL tl_ndone: got %0d want 1", done_cnt - d0); end
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL tl_release: got %b want 0", cpu_hold); end
  endtask

  task automatic test_timeout();
    int base, d0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL to_early: got %b want 0", load_err); end
    repeat (20) @(negedge clk);
    compared++; if (load_err !== 1'b1) begin mismatched++; $display("FAIL to_err: got %b want 1", load_err); end
    compared++; if (cpu_hold !== 1'b1) begin mismatched++; $display("FAIL to_hold: got %b want 1", cpu_hold); end
    compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("FAIL to_ready: got %b want 1", rx_ready); end
    compared++; if (wa_log.size() - base !== 0) begin mismatched++; $display("FAIL to_nwrites: got %0d want 0", wa_log.size() - base); end
    compared++; if (done_cnt - d0 !== 0) begin mismatched++; $display("FAIL to_ndone: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_sync_in_data();
    int base;
    base = wa_log.size();
    seq = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (wa_log.size() - base !== 1) begin mismatched++; $display("FAIL sd_nwrites: got %0d want 1", wa_log.size() - base); end
    if (wa_log.size() > base) begin
      compared++; if (wd_log[base] !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL sd_data: got %h want a5a5a5a5", wd_log[base]); end
    end
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL sd_err: got %b want 0", load_err); end
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL sd_release: got %b want 0", cpu_hold); end
  endtask

  task automatic test_max_len();
    int base, d0, last;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'hA5, 8'h00, 8'h01};
    send_seq();
    for (int w = 0; w < 256; w++) begin
      send_byte(8'(w));
      send_byte(8'h5A);
      send_byte(8'h00);
      send_byte(8'hC3);
    end
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (wa_log.size() - base !== 256) begin mismatched++; $display("FAIL ml_nwrites: got %0d want 256", wa_log.size() - base); end
    if (wa_log.size() >= base + 256) begin
      last = base + 255;
      compared++; if (wa_log[base + 17] !== 32'h44) begin mismatched++; $display("FAIL ml_addr17: got %h want 00000044", wa_log[base + 17]); end
      compared++; if (wd_log[base + 17] !== 32'hC3005A11) begin mismatched++; $display("FAIL ml_data17: got %h want c3005a11", wd_log[base + 17]); end
      compared++; if (wa_log[last] !== 32'h3FC) begin mismatched++; $display("FAIL ml_addr_last: got %h want 000003fc", wa_log[last]); end
      compared++; if (wd_log[last] !== 32'hC3005AFF) begin mismatched++; $display("FAIL ml_data_last: got %h want c3005aff", wd_log[last]); end
    end
    compared++; if (words_written !== 9'h100) begin mismatched++; $display("FAIL ml_ww: got %0d want 256", words_written); end
    compared++; if (load_err !== 1'b0) begin mismatched++; $display("FAIL ml_err: got %b want 0", load_err); end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL ml_ndone: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int base, d0;
    base = wa_log.size();
    seq = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    compared++; if (words_written !== 9'd1) begin mismatched++; $display("FAIL rm_ww_pre: got %0d want 1", words_written); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++; if (rx_ready !== 1'b1) begin mismatched++; $display("FAIL rm_ready: got %b want 1", rx_ready); end
    compared++; if (cpu_hold !== 1'b0) begin mismatched++; $display("FAIL rm_hold: got %b want 0", cpu_hold); end
    compared++; if (words_written !== 9'd0) begin mismatched++; $display("FAIL rm_ww: got %0d want 0", words_written); end
    compared++; if (mem_wdata !== 32'h0) begin mismatched++; $display("FAIL rm_wdata: got %h want 00000000", mem_wdata); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rm_we: got %b want 0", mem_we); end
    reset = 1'b0;
    base = wa_log.size(); d0 = done_cnt;
    seq = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    send_seq();
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (wa_log.size() - base !== 1) begin mismatched++; $display("FAIL rm_nwrites: got %0d want 1", wa_log.size() - base); end
    if (wa_log.size() > base) begin
      compared++; if (wa_log[base] !== 32'h0) begin mismatched++; $display("FAIL rm_addr: got %h want 00000000", wa_log[base]); end
      compared++; if (wd_log[base] !== 32'h0A0B0C0D) begin mismatched++; $display("FAIL rm_data: got %h want 0a0b0c0d", wd_log[base]); end
    end
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL rm_ndone: got %0d want 1", done_cnt - d0); end
    compared++; if (words_written !== 9'd1) begin mismatched++; $display("FAIL rm_ww_post: got %0d want 1", words_written); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_leading_garbage();
    test_len_zero();
    test_too_long();
    test_timeout();
    test_sync_in_data();
    test_max_len();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
